// File: rtl/step_sched.sv
// step_sched: multi-channel step/dir pulse scheduler fed from the movement queue.
// Each channel times its steps against the shared free-running counter.
`timescale 1ns/1ps
module step_sched #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  counter,
   input  logic [63:0]       mq_data,
   input  logic              mq_avail,
   output logic              mq_pull,
   input  logic              shutdown,
   output logic [NUM_CH-1:0] step,
   output logic [NUM_CH-1:0] dir,
   output logic [NUM_CH-1:0] busy
);
   typedef enum logic [1:0] {StIdle, StWait, StHigh, StLow} ch_state_e;

   localparam logic [7:0] PulseLast = 8'(PULSE_W - 1);

   // Head entry fields
   logic [CNT_W-1:0] e_start;
   logic [15:0]      e_interval;
   logic [9:0]       e_count;
   logic [2:0]       e_ch;
   logic             e_dir;
   logic             unused_bits;

   assign e_start     = CNT_W'(mq_data[31:0]);
   assign e_interval  = mq_data[47:32];
   assign e_count     = mq_data[57:48];
   assign e_ch        = mq_data[60:58];
   assign e_dir       = mq_data[61];
   assign unused_bits = ^mq_data[63:62];

   logic [NUM_CH-1:0] ch_idle;
   logic [NUM_CH-1:0] load;
   logic              target_ok;
   logic              dispatch;
   logic              mq_pull_q;

   // Head entry may go only if its channel is idle; out-of-range channels are simply dropped.
   always_comb begin
      target_ok = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (e_ch == 3'(i)) target_ok = ch_idle[i];
      end
   end

   // The cycle mq_pull is high is the holdoff cycle: mq_data is stale then.
   assign dispatch = mq_avail & ~shutdown & ~mq_pull_q & target_ok;

   // Registered single-cycle pop strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mq_pull_q <= 1'b0;
      else        mq_pull_q <= dispatch;
   end

   assign mq_pull = mq_pull_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ch_state_e        state_q;
      logic [CNT_W-1:0] next_time_q;
      logic [15:0]      interval_q;
      logic [9:0]       remaining_q;
      logic [7:0]       pcnt_q;
      logic             step_q;
      logic             dir_q;
      logic             busy_q;
      logic [CNT_W-1:0] lag;
      logic             due;
      logic             pulse_end;
      logic             fire;

      // Wrap-safe "due or late": the counter is at or past next_time by less than half the range.
      assign lag       = counter - next_time_q;
      assign due       = ~lag[CNT_W-1];
      assign pulse_end = (pcnt_q == PulseLast);
      // Firing straight out of the last LOW cycle keeps late steps at exactly PULSE_W low.
      assign fire      = due & ((state_q == StWait) |
                                ((state_q == StLow) & pulse_end & (remaining_q != '0)));
      assign load[g]    = dispatch & (e_ch == 3'(g));
      assign ch_idle[g] = (state_q == StIdle);

      // Per-channel FSM: load, fire, pulse high/low timing and shutdown abort.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q     <= StIdle;
            next_time_q <= '0;
            interval_q  <= '0;
            remaining_q <= '0;
            pcnt_q      <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
         end else if (shutdown) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            pcnt_q      <= '0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
         end else if (load[g]) begin
            dir_q       <= e_dir;
            next_time_q <= e_start;
            interval_q  <= e_interval;
            remaining_q <= e_count;
            pcnt_q      <= '0;
            if (e_count != '0) begin
               state_q <= StWait;
               busy_q  <= 1'b1;
            end
         end else if (fire) begin
            state_q     <= StHigh;
            step_q      <= 1'b1;
            busy_q      <= 1'b1;
            remaining_q <= remaining_q - 10'd1;
            next_time_q <= next_time_q + CNT_W'(interval_q);
            pcnt_q      <= '0;
         end else begin
            case (state_q)
               StHigh: begin
                  if (pulse_end) begin
                     step_q  <= 1'b0;
                     state_q <= StLow;
                     pcnt_q  <= '0;
                  end else begin
                     pcnt_q <= pcnt_q + 8'd1;
                  end
               end
               StLow: begin
                  if (pulse_end) begin
                     pcnt_q <= '0;
                     if (remaining_q != '0) begin
                        state_q <= StWait;
                     end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     pcnt_q <= pcnt_q + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end

      assign step[g] = step_q;
      assign dir[g]  = dir_q;
      assign busy[g] = busy_q;
   end

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: a small moveq model, step edge monitor and hand-computed checks.
`timescale 1ns/1ps
module tb_step_sched;
   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned PULSE_W = 4;
   localparam int unsigned CNT_W   = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CNT_W-1:0]  counter;
   logic [63:0]       mq_data;
   logic              mq_avail;
   logic              mq_pull;
   logic              shutdown;
   logic [NUM_CH-1:0] step;
   logic [NUM_CH-1:0] dir;
   logic [NUM_CH-1:0] busy;

   step_sched #(
      .NUM_CH  (NUM_CH),
      .PULSE_W (PULSE_W),
      .CNT_W   (CNT_W)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .counter  (counter),
      .mq_data  (mq_data),
      .mq_avail (mq_avail),
      .mq_pull  (mq_pull),
      .shutdown (shutdown),
      .step     (step),
      .dir      (dir),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Counter behaves like a register: it advances on every rising edge, and can be rebased.
   logic [31:0] ticks = '0;
   logic [31:0] cnt_base = '0;
   always @(posedge clk) ticks <= ticks + 32'd1;
   assign counter = cnt_base + ticks;

   int n_chk = 0;
   int n_pass = 0;

   logic [63:0] mq[$];
   logic [31:0] pull_t[$];
   logic [31:0] rise_t[$];
   logic [31:0] rise_c[$];
   logic [31:0] fall_t[$];
   logic [1:0]  mon_ch = 2'd0;
   logic        prev_step = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] mk(input logic [2:0] ch, input logic d, input logic [9:0] n,
                                      input logic [15:0] iv, input logic [31:0] st);
      return {2'b00, d, ch, n, iv, st};
   endfunction

   // One cycle: sample at the falling edge, then update the queue model.
   task automatic cyc();
      @(negedge clk);
      if (step[mon_ch] && !prev_step) begin
         rise_t.push_back(ticks);
         rise_c.push_back(counter);
      end
      if (!step[mon_ch] && prev_step) fall_t.push_back(ticks);
      prev_step = step[mon_ch];
      if (mq_pull) begin
         pull_t.push_back(ticks);
         if (mq.size() > 0) void'(mq.pop_front());
      end
      mq_avail = (mq.size() > 0);
      mq_data  = mq_avail ? mq[0] : 64'd0;
   endtask

   task automatic clear_mon(input logic [1:0] ch);
      mon_ch = ch;
      prev_step = step[ch];
      pull_t.delete();
      rise_t.delete();
      rise_c.delete();
      fall_t.delete();
   endtask

   task automatic set_cnt(input logic [31:0] v);
      cnt_base = v - ticks;
   endtask

   logic [31:0]       t_busy;
   logic              early;
   logic [3*NUM_CH-1:0] snap;

   initial begin
      rst_n = 1'b0;
      shutdown = 1'b0;
      mq_avail = 1'b0;
      mq_data = '0;
      repeat (3) @(negedge clk);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_pull", mq_pull, 0);
      rst_n = 1'b1;
      cyc();

      // 1: single move, steps at 101/121/141, 4 cycles high, busy drops after final LOW
      set_cnt(32'd0);
      clear_mon(2'd0);
      mq.push_back(mk(3'd0, 1'b1, 10'd3, 16'd20, 32'd100));
      for (int k = 0; k < 20 && pull_t.size() == 0; k++) cyc();
      check("t1_pull", pull_t.size(), 1);
      check("t1_dir_on_load", dir[0], 1);
      check("t1_busy_on_load", busy[0], 1);
      for (int k = 0; k < 300 && busy[0]; k++) cyc();
      t_busy = ticks;
      check("t1_idle", busy[0], 0);
      check("t1_npull", pull_t.size(), 1);
      check("t1_nrise", rise_c.size(), 3);
      if (rise_c.size() == 3 && fall_t.size() == 3) begin
         check("t1_rise0", rise_c[0], 101);
         check("t1_rise1", rise_c[1], 121);
         check("t1_rise2", rise_c[2], 141);
         for (int i = 0; i < 3; i++) check("t1_high_w", fall_t[i] - rise_t[i], PULSE_W);
         check("t1_busy_drop", t_busy - fall_t[2], PULSE_W);
      end

      // 2: wrap-around of start time and next_time
      set_cnt(32'hFFFF_FFE0);
      clear_mon(2'd0);
      mq.push_back(mk(3'd0, 1'b0, 10'd2, 16'h0020, 32'hFFFF_FFF0));
      for (int k = 0; k < 10 && pull_t.size() == 0; k++) cyc();
      check("t2_pull", pull_t.size(), 1);
      for (int k = 0; k < 200 && busy[0]; k++) cyc();
      check("t2_idle", busy[0], 0);
      check("t2_nrise", rise_c.size(), 2);
      if (rise_c.size() == 2) begin
         check("t2_rise0", rise_c[0], 32'hFFFF_FFF1);
         check("t2_rise1", rise_c[1], 32'h0000_0011);
      end
      check("t2_dir", dir[0], 0);

      // 3: late start, back-to-back steps with exact high and low widths
      set_cnt(32'd1000);
      clear_mon(2'd0);
      mq.push_back(mk(3'd0, 1'b1, 10'd3, 16'd1, 32'd5));
      for (int k = 0; k < 10 && pull_t.size() == 0; k++) cyc();
      for (int k = 0; k < 100 && busy[0]; k++) cyc();
      check("t3_idle", busy[0], 0);
      check("t3_nrise", rise_t.size(), 3);
      if (rise_t.size() == 3 && fall_t.size() == 3 && pull_t.size() == 1) begin
         check("t3_late_lat", rise_t[0] - pull_t[0], 1);
         for (int i = 0; i < 3; i++) check("t3_high_w", fall_t[i] - rise_t[i], PULSE_W);
         for (int i = 0; i < 2; i++) check("t3_low_w", rise_t[i+1] - fall_t[i], PULSE_W);
      end

      // 4: head-of-line blocking behind a busy channel 1
      set_cnt(32'd0);
      clear_mon(2'd2);
      early = 1'b0;
      mq.push_back(mk(3'd1, 1'b1, 10'd10, 16'd0, 32'd0));
      mq.push_back(mk(3'd1, 1'b0, 10'd1, 16'd0, 32'd0));
      mq.push_back(mk(3'd2, 1'b1, 10'd1, 16'd0, 32'd0));
      for (int k = 0; k < 10 && pull_t.size() == 0; k++) cyc();
      for (int k = 0; k < 200 && busy[1]; k++) begin
         cyc();
         if (busy[2]) early = 1'b1;
      end
      t_busy = ticks;
      check("t4_ch1_done", busy[1], 0);
      check("t4_hol_npull", pull_t.size(), 1);
      check("t4_ch2_waits", early, 0);
      for (int k = 0; k < 10 && pull_t.size() < 3; k++) cyc();
      check("t4_npull", pull_t.size(), 3);
      if (pull_t.size() == 3) begin
         check("t4_reload_lat", pull_t[1] - t_busy, 1);
         check("t4_pull_gap", pull_t[2] - pull_t[1], 2);
      end
      check("t4_ch2_busy", busy[2], 1);
      for (int k = 0; k < 100 && busy != 0; k++) cyc();
      check("t4_all_idle", busy, 0);

      // 5: shutdown mid-HIGH, queue held, dispatch resumes after release
      set_cnt(32'd0);
      clear_mon(2'd0);
      mq.push_back(mk(3'd0, 1'b1, 10'd5, 16'd50, 32'd10));
      mq.push_back(mk(3'd0, 1'b0, 10'd1, 16'd0, 32'd0));
      for (int k = 0; k < 10 && pull_t.size() == 0; k++) cyc();
      for (int k = 0; k < 50 && rise_t.size() == 0; k++) cyc();
      check("t5_rise", rise_t.size(), 1);
      cyc();
      cyc();
      check("t5_mid_high", step[0], 1);
      shutdown = 1'b1;
      cyc();
      check("t5_sd_step", step[0], 0);
      check("t5_sd_busy", busy[0], 0);
      check("t5_sd_dir", dir[0], 1);
      for (int k = 0; k < 6; k++) begin
         cyc();
         check("t5_sd_nopull", mq_pull, 0);
      end
      check("t5_sd_npull", pull_t.size(), 1);
      shutdown = 1'b0;
      for (int k = 0; k < 10 && pull_t.size() < 2; k++) cyc();
      check("t5_resume_pull", pull_t.size(), 2);
      check("t5_resume_dir", dir[0], 0);
      for (int k = 0; k < 20 && rise_t.size() < 2; k++) cyc();
      check("t5_resume_rise", rise_t.size(), 2);
      for (int k = 0; k < 30 && busy[0]; k++) cyc();
      check("t5_idle", busy[0], 0);

      // 6: count=0 entry, out-of-range channel, async reset mid-pulse
      clear_mon(2'd3);
      mq.push_back(mk(3'd3, 1'b1, 10'd0, 16'd0, 32'd0));
      for (int k = 0; k < 10 && pull_t.size() == 0; k++) cyc();
      cyc();
      cyc();
      check("t6_c0_pull", pull_t.size(), 1);
      check("t6_c0_dir", dir[3], 1);
      check("t6_c0_busy", busy[3], 0);
      check("t6_c0_step", rise_t.size(), 0);
      snap = {step, dir, busy};
      mq.push_back(mk(3'd6, 1'b0, 10'd5, 16'd0, 32'd0));
      for (int k = 0; k < 10 && pull_t.size() < 2; k++) cyc();
      repeat (3) cyc();
      check("t6_bad_ch_pull", pull_t.size(), 2);
      check("t6_bad_ch_outs", {step, dir, busy}, snap);
      clear_mon(2'd0);
      mq.push_back(mk(3'd0, 1'b1, 10'd4, 16'd0, 32'd0));
      mq.push_back(mk(3'd1, 1'b1, 10'd4, 16'd0, 32'd0));
      for (int k = 0; k < 10 && pull_t.size() < 2; k++) cyc();
      check("t6_pre_pull", mq_pull, 1);
      check("t6_pre_step", step[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_arst_step", step, 0);
      check("t6_arst_dir", dir, 0);
      check("t6_arst_busy", busy, 0);
      check("t6_arst_pull", mq_pull, 0);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      cyc();
      check("t6_post_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global time limit so a stuck run still reports.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
